rr_mux_arbiter: RTL
===================

Name: rr_mux_arbiter

Overview:
Upstream select stage for the 2-to-1 mux.
- Two requesters (A, B) present data with valid/ready handshakes.
- A round-robin arbiter picks one per cycle and registers the winner's data into a single-entry output stage.
- It drives SEL with the mux convention: 0 = A, 1 = B. OUT_BAR is the complement of the output data.
- It also keeps saturating per-side grant counters for debug and fairness checks.

Parameters:
WIDTH, 1, data width of A_DATA, B_DATA, OUT_DATA, OUT_BAR
CNT_WIDTH, 8, width of each saturating grant counter

Ports:
CLK  input  1  system clock, all state on rising edge
RST_N  input  1  asynchronous active-low reset
A_VALID  input  1  requester A has data
A_DATA  input  WIDTH  requester A payload
A_READY  output  1  A transfer accepted this cycle
B_VALID  input  1  requester B has data
B_DATA  input  WIDTH  requester B payload
B_READY  output  1  B transfer accepted this cycle
SEL  output  1  source of current OUT_DATA (0 = A, 1 = B)
OUT_VALID  output  1  output register holds data
OUT_DATA  output  WIDTH  registered selected payload
OUT_BAR  output  WIDTH  bitwise ~OUT_DATA (combinational from register)
OUT_READY  input  1  downstream consumes when OUT_VALID && OUT_READY
A_GRANTS  output  CNT_WIDTH  saturating count of A transfers
B_GRANTS  output  CNT_WIDTH  saturating count of B transfers

Behaviour:
- Reset (RST_N low, asynchronous, any time):
  - OUT_VALID = 0, OUT_DATA = 0, OUT_BAR = all ones, SEL = 0.
  - Priority pointer PRI = 0 (A preferred).
  - A_GRANTS = 0, B_GRANTS = 0.
  - Any in-flight output word is dropped. A_READY and B_READY are 0 while RST_N is low.
- Load condition: can_load = !OUT_VALID || OUT_READY. A full register consumed in the same cycle may reload, giving 1 word/cycle throughput.
- Grant (combinational):
  - Only A_VALID: grant A.
  - Only B_VALID: grant B.
  - Both valid: grant A if PRI = 0, else grant B.
  - Neither valid: no grant.
- Ready outputs:
  - A_READY = can_load && grant A.
  - B_READY = can_load && grant B.
  - Ready may depend on VALID (combinational). At most one READY is high in any cycle.
- State: two states tracked by OUT_VALID.
  - EMPTY -> FULL on any grant.
  - FULL -> FULL on consume-and-grant, or when not consumed.
  - FULL -> EMPTY on consume with no grant.
- On a transfer (rising edge where xx_VALID && xx_READY):
  - OUT_DATA <= granted data; SEL <= 0 for A, 1 for B; OUT_VALID <= 1.
  - PRI <= 1 after an A grant, PRI <= 0 after a B grant.
  - The winner's grant counter increments, saturating at 2^CNT_WIDTH-1 with no wrap.
- No transfer:
  - OUT_DATA, SEL, PRI and counters hold.
  - OUT_VALID clears only if OUT_VALID && OUT_READY.
- Stall: while OUT_VALID && !OUT_READY, OUT_DATA, SEL and OUT_BAR are stable and both READYs are 0.
- PRI moves only on an actual transfer. A requester that is stalled keeps its priority.
- Latency: input transfer to OUT_VALID is 1 cycle.
- Requesters must hold VALID and DATA until READY. Behaviour is undefined if DATA changes while VALID is held without READY.

Test Plan:
1. Reset then A only: A_VALID = 1, A_DATA = 1, B_VALID = 0, OUT_READY = 1 -> A_READY = 1; next edge OUT_VALID = 1, OUT_DATA = 1, OUT_BAR = 0, SEL = 0, A_GRANTS = 1.
2. Both valid continuously (A_DATA = 1, B_DATA = 0), OUT_READY = 1, four cycles -> SEL sequence 0,1,0,1; OUT_DATA 1,0,1,0; A_GRANTS = 2, B_GRANTS = 2.
3. Backpressure: OUT_VALID = 1 with SEL = 1 and OUT_READY = 0 for 3 cycles, both requesters valid -> A_READY = B_READY = 0; OUT_DATA, SEL and PRI unchanged. Raise OUT_READY -> A is granted next (PRI = 0).
4. Drain: single B transfer, then B_VALID = 0, OUT_READY = 1 -> OUT_VALID rises one cycle after the transfer and falls the following cycle; SEL stays 1, OUT_DATA holds.
5. Saturation with CNT_WIDTH = 2: six A-only transfers -> A_GRANTS reads 1,2,3,3,3,3; B_GRANTS = 0.
6. Mid-operation reset: assert RST_N = 0 between edges while OUT_VALID = 1, SEL = 1 -> OUT_VALID, SEL and counters clear immediately; after release, with both requesters valid, A is granted first.

Source files
------------

// File: rtl/rr_mux_arbiter.sv
// rtl/rr_mux_arbiter.sv - round-robin 2:1 select stage with single-entry output register
// Arbitrates requesters A/B onto one registered output and counts grants per side.
module rr_mux_arbiter #(
  parameter int WIDTH     = 1,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 A_VALID,
  input  logic [WIDTH-1:0]     A_DATA,
  output logic                 A_READY,
  input  logic                 B_VALID,
  input  logic [WIDTH-1:0]     B_DATA,
  output logic                 B_READY,
  output logic                 SEL,
  output logic                 OUT_VALID,
  output logic [WIDTH-1:0]     OUT_DATA,
  output logic [WIDTH-1:0]     OUT_BAR,
  input  logic                 OUT_READY,
  output logic [CNT_WIDTH-1:0] A_GRANTS,
  output logic [CNT_WIDTH-1:0] B_GRANTS
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t               state_q, state_d;
  logic                 sel_q, sel_d;
  logic                 pri_q, pri_d;
  logic [WIDTH-1:0]     data_q, data_d;
  logic [CNT_WIDTH-1:0] a_cnt_q, a_cnt_d;
  logic [CNT_WIDTH-1:0] b_cnt_q, b_cnt_d;

  logic can_load;
  logic grant_a;
  logic grant_b;
  logic xfer_a;
  logic xfer_b;

  assign can_load = (state_q == EMPTY) || OUT_READY;
  // pri_q = 0 favours A on contention, 1 favours B
  assign grant_a  = A_VALID && (!B_VALID || !pri_q);
  assign grant_b  = B_VALID && (!A_VALID ||  pri_q);
  assign xfer_a   = RST_N && can_load && grant_a;
  assign xfer_b   = RST_N && can_load && grant_b;

  assign A_READY   = xfer_a;
  assign B_READY   = xfer_b;
  assign OUT_VALID = (state_q == FULL);
  assign OUT_DATA  = data_q;
  assign OUT_BAR   = ~data_q;
  assign SEL       = sel_q;
  assign A_GRANTS  = a_cnt_q;
  assign B_GRANTS  = b_cnt_q;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    pri_d   = pri_q;
    data_d  = data_q;
    a_cnt_d = a_cnt_q;
    b_cnt_d = b_cnt_q;
    if (xfer_a) begin
      state_d = FULL;
      data_d  = A_DATA;
      sel_d   = 1'b0;
      pri_d   = 1'b1;
      if (a_cnt_q != {CNT_WIDTH{1'b1}}) a_cnt_d = a_cnt_q + 1'b1;
    end else if (xfer_b) begin
      state_d = FULL;
      data_d  = B_DATA;
      sel_d   = 1'b1;
      pri_d   = 1'b0;
      if (b_cnt_q != {CNT_WIDTH{1'b1}}) b_cnt_d = b_cnt_q + 1'b1;
    end else if ((state_q == FULL) && OUT_READY) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= EMPTY;
      sel_q   <= 1'b0;
      pri_q   <= 1'b0;
      data_q  <= '0;
      a_cnt_q <= '0;
      b_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      pri_q   <= pri_d;
      data_q  <= data_d;
      a_cnt_q <= a_cnt_d;
      b_cnt_q <= b_cnt_d;
    end
  end

endmodule
